// File: rtl/pe_mult_pipe_if.sv
// Token bus of the PE multiply stage: operand side from fetch, result side to the
// accumulate stage, plus the clamp-count sideband.
interface pe_mult_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6,
   parameter int LANES  = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_act;
   logic [LANES*DATA_W-1:0]   in_w;
   logic [ADDR_W-1:0]         in_addr;
   logic                      in_sat_en;
   logic                      out_valid;
   logic                      out_ready;
   logic [ADDR_W-1:0]         out_addr;
   logic [LANES*DATA_W-1:0]   out_result;
   logic [LANES-1:0]          out_sat;
   logic                      sat_cnt_clr;
   logic [15:0]               sat_count;

   modport master (
      output in_valid, in_act, in_w, in_addr, in_sat_en, out_ready, sat_cnt_clr,
      input  in_ready, out_valid, out_addr, out_result, out_sat, sat_count
   );

   modport slave (
      input  in_valid, in_act, in_w, in_addr, in_sat_en, out_ready, sat_cnt_clr,
      output in_ready, out_valid, out_addr, out_result, out_sat, sat_count
   );
endinterface

// File: rtl/pe_mult_pipe.sv
// LANES-wide signed fixed-point multiply with round-half-up and optional clamping,
// followed by a STAGES-deep elastic register pipeline carrying the output address.
module pe_mult_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ADDR_W = 6,
   parameter int LANES  = 2,
   parameter int STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   pe_mult_pipe_if.slave  bus
);
   localparam int PROD_W = 2 * DATA_W;
   localparam int EXT_W  = PROD_W + 1;
   localparam int RES_W  = LANES * DATA_W;

   logic [RES_W-1:0] lane_res;
   logic [LANES-1:0] lane_sat;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
      localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

      logic signed [PROD_W-1:0] act_x;
      logic signed [PROD_W-1:0] w_x;
      logic signed [PROD_W-1:0] prod;
      logic signed [EXT_W-1:0]  r;
      logic [DATA_W-1:0]        res;
      logic                     sat;

      assign act_x = {{DATA_W{bus.in_act[i*DATA_W+DATA_W-1]}}, bus.in_act[i*DATA_W +: DATA_W]};
      assign w_x   = {{DATA_W{bus.in_w[i*DATA_W+DATA_W-1]}}, bus.in_w[i*DATA_W +: DATA_W]};
      assign prod  = act_x * w_x;

      // One guard bit above the product keeps the rounding bias from overflowing.
      if (FRAC_W > 0) begin : g_round
         logic signed [EXT_W-1:0] biased;
         assign biased = {prod[PROD_W-1], prod} + ({{(EXT_W-1){1'b0}}, 1'b1} << (FRAC_W - 1));
         assign r      = biased >>> FRAC_W;
      end else begin : g_trunc
         assign r = {prod[PROD_W-1], prod};
      end

      always_comb begin
         res = r[DATA_W-1:0];
         sat = 1'b0;
         if (bus.in_sat_en) begin
            if (r > SAT_MAX) begin
               res = {1'b0, {(DATA_W-1){1'b1}}};
               sat = 1'b1;
            end else if (r < SAT_MIN) begin
               res = {1'b1, {(DATA_W-1){1'b0}}};
               sat = 1'b1;
            end else begin
               sat = 1'b0;
            end
         end else begin
            sat = 1'b0;
         end
      end

      assign lane_res[i*DATA_W +: DATA_W] = res;
      assign lane_sat[i]                  = sat;
   end

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] load_en;
   logic              all_full;
   logic [RES_W-1:0]  res_q  [STAGES];
   logic [RES_W-1:0]  res_d  [STAGES];
   logic [LANES-1:0]  sat_q  [STAGES];
   logic [LANES-1:0]  sat_d  [STAGES];
   logic [ADDR_W-1:0] addr_q [STAGES];
   logic [ADDR_W-1:0] addr_d [STAGES];

   // A slot may load unless it and every slot after it are full while the sink stalls.
   always_comb begin
      all_full = 1'b1;
      load_en  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         all_full   = all_full & valid_q[k];
         load_en[k] = ~all_full | bus.out_ready;
      end
   end

   always_comb begin
      valid_d[0] = bus.in_valid;
      res_d[0]   = lane_res;
      sat_d[0]   = lane_sat;
      addr_d[0]  = bus.in_addr;
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         res_d[k]   = res_q[k-1];
         sat_d[k]   = sat_q[k-1];
         addr_d[k]  = addr_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            res_q[k]  <= '0;
            sat_q[k]  <= '0;
            addr_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load_en[k]) begin
               valid_q[k] <= valid_d[k];
               if (valid_d[k]) begin
                  res_q[k]  <= res_d[k];
                  sat_q[k]  <= sat_d[k];
                  addr_q[k] <= addr_d[k];
               end
            end
         end
      end
   end

   logic        out_hs;
   logic [16:0] sat_sum;
   logic [15:0] sat_cnt_q;
   logic [15:0] sat_cnt_d;

   assign out_hs = valid_q[STAGES-1] & bus.out_ready;

   // Clear has priority over a delivery in the same cycle.
   always_comb begin
      sat_sum = {1'b0, sat_cnt_q};
      for (int i = 0; i < LANES; i++) begin
         sat_sum = sat_sum + {16'd0, sat_q[STAGES-1][i]};
      end
      if (bus.sat_cnt_clr) begin
         sat_cnt_d = 16'd0;
      end else if (out_hs) begin
         sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end else begin
         sat_cnt_d = sat_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt_q <= 16'd0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign bus.in_ready   = load_en[0];
   assign bus.out_valid  = valid_q[STAGES-1];
   assign bus.out_result = res_q[STAGES-1];
   assign bus.out_sat    = sat_q[STAGES-1];
   assign bus.out_addr   = addr_q[STAGES-1];
   assign bus.sat_count  = sat_cnt_q;
endmodule

// File: tb/tb_pe_mult_pipe.sv
// Bench for pe_mult_pipe: directed rounding/saturation/back-pressure/reset cases on the
// default configuration, plus random tokens on two 4-lane, FRAC_W=0 variants.
module tb_pe_mult_pipe;
   typedef struct packed {
      logic [5:0]  addr;
      logic [63:0] res;
      logic [3:0]  sat;
   } tok_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int   n_tests = 0;
   int   n_fail  = 0;
   tok_t qa[$];
   tok_t qb[$];
   tok_t qc[$];
   int   cnt_a    = 0;
   bit   hold_a   = 1'b0;
   logic [31:0] hold_res;
   logic [5:0]  hold_addr;
   logic [1:0]  hold_sat;
   int   addr_seq = 0;
   int   sent_b = 0, sent_c = 0, recv_b = 0, recv_c = 0;

   pe_mult_pipe_if #(.DATA_W(16), .ADDR_W(6), .LANES(2)) ifa ();
   pe_mult_pipe_if #(.DATA_W(16), .ADDR_W(6), .LANES(4)) ifb ();
   pe_mult_pipe_if #(.DATA_W(16), .ADDR_W(6), .LANES(4)) ifc ();

   pe_mult_pipe #(.DATA_W(16), .FRAC_W(8), .ADDR_W(6), .LANES(2), .STAGES(2))
      dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   pe_mult_pipe #(.DATA_W(16), .FRAC_W(0), .ADDR_W(6), .LANES(4), .STAGES(1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   pe_mult_pipe #(.DATA_W(16), .FRAC_W(0), .ADDR_W(6), .LANES(4), .STAGES(3))
      dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, round half up, then clamp or wrap to 16 bits.
   function automatic void ref_lane(input logic [15:0] a, input logic [15:0] w, input int frac,
                                    input bit se, output logic [15:0] r, output bit s);
      longint p;
      longint q;
      p = longint'($signed(a)) * longint'($signed(w));
      if (frac > 0) q = (p + (longint'(1) <<< (frac - 1))) >>> frac;
      else          q = p;
      s = 1'b0;
      if (se && q > 32767) begin
         r = 16'h7FFF; s = 1'b1;
      end else if (se && q < -32768) begin
         r = 16'h8000; s = 1'b1;
      end else begin
         r = q[15:0];
      end
   endfunction

   function automatic tok_t model_tok(input logic [63:0] act, input logic [63:0] w, input int lanes,
                                      input int frac, input bit se, input logic [5:0] addr);
      tok_t t;
      logic [15:0] r;
      bit s;
      t = '0;
      t.addr = addr;
      for (int i = 0; i < lanes; i++) begin
         ref_lane(act[i*16 +: 16], w[i*16 +: 16], frac, se, r, s);
         t.res[i*16 +: 16] = r;
         t.sat[i]          = s;
      end
      return t;
   endfunction

   function automatic logic [15:0] rand_op();
      if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 511)) - 16'd256;
      else                           return 16'($urandom);
   endfunction

   // One cycle on the default DUT: drive at negedge, sample 1 time unit later.
   task automatic step_a(input bit v, input logic [31:0] act, input logic [31:0] w,
                         input logic [5:0] addr, input bit se, input bit ordy, input bit clr,
                         output bit acc, output bit del, output bit rdy,
                         output logic [31:0] r, output logic [1:0] s);
      tok_t t;
      @(negedge clk);
      ifa.in_valid    = v;
      ifa.in_act      = act;
      ifa.in_w        = w;
      ifa.in_addr     = addr;
      ifa.in_sat_en   = se;
      ifa.out_ready   = ordy;
      ifa.sat_cnt_clr = clr;
      #1;
      rdy = ifa.in_ready;
      acc = v && rdy;
      del = ifa.out_valid && ordy;
      r   = ifa.out_result;
      s   = ifa.out_sat;
      chk("a_sat_count", 64'(ifa.sat_count), 64'(cnt_a));
      if (hold_a) begin
         chk("a_hold_valid", 64'(ifa.out_valid), 64'd1);
         chk("a_hold_result", 64'(ifa.out_result), 64'(hold_res));
         chk("a_hold_addr", 64'(ifa.out_addr), 64'(hold_addr));
         chk("a_hold_sat", 64'(ifa.out_sat), 64'(hold_sat));
      end
      t = '0;
      if (del) begin
         chk("a_out_expected", 64'(qa.size() != 0), 64'd1);
         if (qa.size() != 0) begin
            t = qa.pop_front();
            chk("a_result", 64'(ifa.out_result), t.res);
            chk("a_sat", 64'(ifa.out_sat), 64'(t.sat));
            chk("a_addr", 64'(ifa.out_addr), 64'(t.addr));
         end
      end
      hold_a    = ifa.out_valid && !ordy;
      hold_res  = ifa.out_result;
      hold_addr = ifa.out_addr;
      hold_sat  = ifa.out_sat;
      if (acc) qa.push_back(model_tok({32'd0, act}, {32'd0, w}, 2, 8, se, addr));
      if (clr)      cnt_a = 0;
      else if (del) cnt_a = (cnt_a + $countones(t.sat) > 65535) ? 65535 : cnt_a + $countones(t.sat);
   endtask

   task automatic single_a(input string tag, input logic [15:0] a0, input logic [15:0] w0,
                           input logic [15:0] a1, input logic [15:0] w1, input bit se,
                           input logic [15:0] exp0, input bit exp_sat0);
      bit acc, del, rdy;
      logic [31:0] r;
      logic [1:0] s;
      int n;
      step_a(1'b1, {a1, a0}, {w1, w0}, 6'(addr_seq), se, 1'b1, 1'b0, acc, del, rdy, r, s);
      addr_seq++;
      chk({tag, "_accept"}, 64'(acc), 64'd1);
      n   = 0;
      del = 1'b0;
      while (!del && n < 20) begin
         step_a(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b0, acc, del, rdy, r, s);
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd2);
      chk({tag, "_lane0"}, 64'(r[15:0]), 64'(exp0));
      chk({tag, "_sat0"}, 64'(s[0]), 64'(exp_sat0));
   endtask

   // One cycle on both 4-lane variants with shared random operands.
   task automatic step_bc(input bit v, input bit ordy);
      logic [63:0] act, w;
      logic [5:0]  addr;
      bit          se;
      tok_t        t;
      for (int i = 0; i < 4; i++) begin
         act[i*16 +: 16] = rand_op();
         w[i*16 +: 16]   = rand_op();
      end
      addr = 6'($urandom);
      se   = 1'($urandom);
      @(negedge clk);
      ifb.in_valid = v && (sent_b < 1000);
      ifc.in_valid = v && (sent_c < 1000);
      ifb.in_act = act;  ifc.in_act = act;
      ifb.in_w = w;      ifc.in_w = w;
      ifb.in_addr = addr; ifc.in_addr = addr;
      ifb.in_sat_en = se; ifc.in_sat_en = se;
      ifb.out_ready = ordy; ifc.out_ready = ordy;
      #1;
      if (ifb.out_valid && ifb.out_ready) begin
         chk("b_out_expected", 64'(qb.size() != 0), 64'd1);
         if (qb.size() != 0) begin
            t = qb.pop_front();
            chk("b_result", ifb.out_result, t.res);
            chk("b_sat", 64'(ifb.out_sat), 64'(t.sat));
            chk("b_addr", 64'(ifb.out_addr), 64'(t.addr));
            recv_b++;
         end
      end
      if (ifc.out_valid && ifc.out_ready) begin
         chk("c_out_expected", 64'(qc.size() != 0), 64'd1);
         if (qc.size() != 0) begin
            t = qc.pop_front();
            chk("c_result", ifc.out_result, t.res);
            chk("c_sat", 64'(ifc.out_sat), 64'(t.sat));
            chk("c_addr", 64'(ifc.out_addr), 64'(t.addr));
            recv_c++;
         end
      end
      if (ifb.in_valid && ifb.in_ready) begin
         qb.push_back(model_tok(act, w, 4, 0, se, addr));
         sent_b++;
      end
      if (ifc.in_valid && ifc.in_ready) begin
         qc.push_back(model_tok(act, w, 4, 0, se, addr));
         sent_c++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached after %0d tests, expected completion", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc, del, rdy, ordy;
      logic [31:0] r;
      logic [1:0] s;
      int sent, recv;

      ifa.in_valid = 1'b0; ifa.in_act = '0; ifa.in_w = '0; ifa.in_addr = '0;
      ifa.in_sat_en = 1'b0; ifa.out_ready = 1'b0; ifa.sat_cnt_clr = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_act = '0; ifb.in_w = '0; ifb.in_addr = '0;
      ifb.in_sat_en = 1'b0; ifb.out_ready = 1'b0; ifb.sat_cnt_clr = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_act = '0; ifc.in_w = '0; ifc.in_addr = '0;
      ifc.in_sat_en = 1'b0; ifc.out_ready = 1'b0; ifc.sat_cnt_clr = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
      chk("rst_out_result", 64'(ifa.out_result), 64'd0);
      chk("rst_out_addr", 64'(ifa.out_addr), 64'd0);
      chk("rst_out_sat", 64'(ifa.out_sat), 64'd0);
      chk("rst_sat_count", 64'(ifa.sat_count), 64'd0);
      chk("rst_b_out_valid", 64'(ifb.out_valid), 64'd0);
      chk("rst_c_out_valid", 64'(ifc.out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_in_ready", 64'(ifa.in_ready), 64'd1);

      single_a("basic", 16'h0180, 16'h0200, 16'h0000, 16'h0000, 1'b0, 16'h0300, 1'b0);
      single_a("round_pos", 16'h0001, 16'h0080, 16'h0003, 16'h0055, 1'b1, 16'h0001, 1'b0);
      single_a("round_neg_half", 16'hFFFF, 16'h0080, 16'hFFFF, 16'hFF00, 1'b1, 16'h0000, 1'b0);
      single_a("round_neg", 16'hFFFF, 16'h0081, 16'h1234, 16'hFEDC, 1'b1, 16'hFFFF, 1'b0);
      single_a("sat_pos", 16'h7F00, 16'h0400, 16'h0001, 16'h0100, 1'b1, 16'h7FFF, 1'b1);
      single_a("sat_neg", 16'h8000, 16'h0200, 16'h8000, 16'h0200, 1'b1, 16'h8000, 1'b1);
      single_a("wrap", 16'h7F00, 16'h0400, 16'h0000, 16'h0000, 1'b0, 16'hFC00, 1'b0);
      chk("sat_count_3", 64'(ifa.sat_count), 64'd3);

      // Clear on the same cycle a clamped token is delivered.
      step_a(1'b1, {16'h0000, 16'h7F00}, {16'h0000, 16'h0400}, 6'd40, 1'b1, 1'b1, 1'b0, acc, del, rdy, r, s);
      step_a(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b0, acc, del, rdy, r, s);
      step_a(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b1, acc, del, rdy, r, s);
      chk("clr_delivery", 64'(del), 64'd1);
      step_a(1'b0, 32'd0, 32'd0, 6'd0, 1'b0, 1'b1, 1'b0, acc, del, rdy, r, s);
      chk("sat_count_cleared", 64'(ifa.sat_count), 64'd0);

      // Back-pressure: 10 tokens, 7 initial stall cycles, then random out_ready.
      sent = 0;
      recv = 0;
      for (int i = 0; i < 400 && recv < 10; i++) begin
         ordy = (i < 7) ? 1'b0 : 1'($urandom);
         step_a(sent < 10, {rand_op(), rand_op()}, {rand_op(), rand_op()}, 6'(sent),
                1'($urandom), ordy, 1'b0, acc, del, rdy, r, s);
         if (i < 2)  chk("bp_in_ready_room", 64'(rdy), 64'd1);
         if (i == 2) chk("bp_in_ready_full", 64'(rdy), 64'd0);
         if (acc) sent++;
         if (del) recv++;
      end
      chk("bp_sent", 64'(sent), 64'd10);
      chk("bp_recv", 64'(recv), 64'd10);
      chk("bp_drained", 64'(qa.size()), 64'd0);

      // Reset with two tokens in flight.
      step_a(1'b1, {16'h7F00, 16'h7F00}, {16'h0400, 16'h0400}, 6'd50, 1'b1, 1'b0, 1'b0, acc, del, rdy, r, s);
      step_a(1'b1, {16'h0100, 16'h0100}, {16'h0100, 16'h0100}, 6'd51, 1'b1, 1'b0, 1'b0, acc, del, rdy, r, s);
      @(posedge clk);
      ifa.in_valid = 1'b0;
      #2;
      chk("rst_mid_precond_valid", 64'(ifa.out_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_out_valid", 64'(ifa.out_valid), 64'd0);
      chk("rst_mid_sat_count", 64'(ifa.sat_count), 64'd0);
      qa.delete();
      cnt_a  = 0;
      hold_a = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", 64'(ifa.in_ready), 64'd1);
      chk("rst_mid_no_stale", 64'(ifa.out_valid), 64'd0);
      single_a("after_reset", 16'h0180, 16'h0200, 16'h0002, 16'h0300, 1'b1, 16'h0300, 1'b0);

      // Parameter variants: 1000 random tokens each under random flow control.
      for (int i = 0; i < 20000 && (recv_b < 1000 || recv_c < 1000); i++) begin
         step_bc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
      end
      chk("b_token_count", 64'(recv_b), 64'd1000);
      chk("c_token_count", 64'(recv_c), 64'd1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pe_mult_pipe.md
# pe_mult_pipe

Parametrised multiplication pipeline stage for the PE datapath. It multiplies LANES signed fixed-point activation/weight pairs per token and rounds each product back to DATA_W bits, saturating when enabled. Results pass through a configurable-depth elastic pipeline with valid/ready back-pressure. It sits between the operand fetch stage and the accumulate (add) stage, and carries the output-activation address alongside each token.

## Interface
- DATA_W, 16: operand/result width, two's complement
- FRAC_W, 8: fractional bits, 0 ≤ FRAC_W < DATA_W
- ADDR_W, 6: output activation address width
- LANES, 2: parallel multiplier lanes, ≥ 1
- STAGES, 2: pipeline register stages, ≥ 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input token valid
- in_ready  out  1  block accepts token this cycle
- in_act  in  LANES*DATA_W  activations; lane i = bits [i*DATA_W +: DATA_W]
- in_w  in  LANES*DATA_W  weights, same packing
- in_addr  in  ADDR_W  output activation address
- in_sat_en  in  1  saturation mode for this token
- out_valid  out  1  output token valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_W  address carried with token
- out_result  out  LANES*DATA_W  rounded products, same packing
- out_sat  out  LANES  per-lane clamp occurred
- sat_cnt_clr  in  1  synchronous clear of sat_count
- sat_count  out  16  saturating count of clamped lanes delivered

## Operation
- Per lane: the full product p = act × w is signed, 2·DATA_W bits.
- Rounding is round-half-up: if FRAC_W > 0, r = (p + 2^(FRAC_W−1)) >>> FRAC_W (arithmetic shift). The addition must not overflow; compute it at 2·DATA_W+1 bits.
- in_sat_en=1: clamp r to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. out_sat[i]=1 only when the clamp changed the value.
- in_sat_en=0: result is r[DATA_W−1:0] (wrap). out_sat[i]=0.
- Rounding and saturation are applied before the first register. The token (result, sat flags, addr) then moves through STAGES register slots.
- Each slot has a valid bit. Slot k loads from its predecessor when its own valid is 0 or it is advancing; otherwise it holds.
- The last slot advances on out_valid && out_ready. Bubbles collapse.
- in_ready = !valid[0] || advance[0]. The combinational ready chain from out_ready to in_ready is permitted.
- A token is accepted on in_valid && in_ready. Tokens are never dropped, duplicated or reordered.
- Data registers load only on a slot load. Stalled outputs hold stable.
- sat_count adds popcount(out_sat) on each output handshake and saturates at 0xFFFF.
- When sat_cnt_clr is asserted the count goes to 0. Clear wins over a same-cycle increment.

## Timing
- Latency: STAGES cycles from acceptance to out_valid when there are no stalls.
- Throughput: 1 token/cycle while out_ready=1.
- Capacity: STAGES tokens. With out_ready held low, in_ready drops once all slots are full.
- Reset: all slot valids 0, out_valid 0, out_result 0, out_addr 0, out_sat 0, sat_count 0. in_ready is 1 in the first cycle after reset release.
- Reset mid-stream: in-flight tokens are discarded with no output.
- out_valid, once high, stays high with stable payload until the handshake.

## Test plan
- Basic (DATA_W=16, FRAC_W=8, STAGES=2), lane0 0x0180×0x0200 → out_result lane0 = 0x0300 exactly 2 cycles after acceptance; out_sat=0.
- Rounding: 0x0001×0x0080 → 0x0001; 0xFFFF×0x0080 → 0x0000; 0xFFFF×0x0081 → 0xFFFF.
- Saturation: 0x7F00×0x0400 with sat_en=1 → 0x7FFF, out_sat=1. 0x8000×0x0200 → 0x8000, out_sat=1. The same 0x7F00×0x0400 with sat_en=0 → 0xFC00, out_sat=0. After delivering these 3 clamped lanes, sat_count = 3. sat_cnt_clr on a cycle that also delivers a clamped token → 0.
- Back-pressure: stream 10 tokens with addr 0..9 while out_ready toggles randomly, including 5 consecutive low cycles. in_ready drops after 2 unconsumed tokens. Output order is 0..9 with no loss or duplication, and the payload is stable while stalled.
- Reset mid-operation: assert rst with 2 tokens in flight → out_valid falls immediately and sat_count = 0. After release, the first new token emerges with the correct result and nothing stale appears.
- Parameter sweep: LANES=4, STAGES=1 and 3, FRAC_W=0 (plain truncating product) against a reference model over 1000 random tokens.
